mmio_wsel: RTL and testbench
============================

MMIO_WSEL -- requirements
Module: mmio_wsel

Interface
REQ-001 SHALL have parameter LED_W, default 6, width of the LED register.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port we, input, 1, store valid this cycle.
REQ-005 SHALL have port addr, input, 32, store byte address.
REQ-006 SHALL have port wdata, input, 32, store data, right-aligned.
REQ-007 SHALL have port size, input, 2, store size: 00 byte, 01 half, 10 word; 11 is reserved and treated as misaligned.
REQ-008 SHALL have port inst_retire, input, 1, one instruction retired this cycle.
REQ-009 SHALL have port trmt_ready, input, 1, UART transmitter accepts a byte.
REQ-010 SHALL have ports dmem_wea and imem_wea, output, 4, byte write enables.
REQ-011 SHALL have ports dmem_dina and imem_dina, output, 32, lane-shifted write data.
REQ-012 SHALL have port trmt_data, output, 8, byte to transmit.
REQ-013 SHALL have port trmt_valid, output, 1, trmt_data valid.
REQ-014 SHALL have ports counter_cycle and counter_inst, output, 32, performance counters.
REQ-015 SHALL have port leds, output, LED_W, LED register.
REQ-016 SHALL have port buttons_rd_en, output, 1, button FIFO pop pulse.
REQ-017 SHALL have ports tx_overrun and misalign, output, 1, sticky and pulse error flags.

Function
REQ-018 SHALL decode addr[31:28]: 0001 targets dmem, 0010 targets imem, 0011 targets both, 1000 targets MMIO; all other values SHALL produce no effect.
REQ-019 SHALL drive memory enables combinationally in the same cycle as we: byte → 1 << addr[1:0]; half → 0011 << addr[1:0]; word → 1111.
REQ-020 SHALL replicate the data lanes: byte → wdata[7:0] ×4; half → wdata[15:0] ×2; word → wdata unchanged.
REQ-021 SHALL treat a half store with addr[0]=1, a word store with addr[1:0]≠0, or size=11 as misaligned: all enables 0, no MMIO effect, misign pulsed high for one cycle on the next edge.
REQ-022 SHALL on an MMIO store to offset 0x08 load trmt_data with wdata[7:0] and set trmt_valid at the next edge.
REQ-023 SHALL clear trmt_valid at the edge on which trmt_valid and trmt_ready are both 1.
REQ-024 SHALL ignore a 0x08 store that arrives while trmt_valid=1 and trmt_ready=0, and SHALL set tx_overrun (sticky until reset).
REQ-025 SHALL accept a 0x08 store that coincides with a handshake: the new byte is loaded and trmt_valid stays 1.
REQ-026 SHALL increment counter_cycle every cycle, and SHALL increment counter_inst on each cycle with inst_retire=1; both SHALL wrap modulo 2^32.
REQ-027 SHALL clear both counters to 0 on an MMIO store to 0x18; clear SHALL win over a coincident increment.
REQ-028 SHALL pulse buttons_rd_en for exactly one cycle, at the next edge, after an MMIO store to 0x20.
REQ-029 SHALL on an MMIO store to 0x30 load leds with wdata[LED_W-1:0] at the next edge.
REQ-030 SHALL ignore MMIO stores to any other offset.
REQ-031 SHALL ignore all inputs while we=0, except inst_retire and trmt_ready.

Reset
REQ-032 SHALL on rst_n=0 asynchronously clear trmt_valid, trmt_data, both counters, leds, buttons_rd_en, tx_overrun and misalign to 0; a pending byte SHALL be discarded.
REQ-033 SHALL resume counting on the first edge after rst_n deasserts.

Structure
REQ-034 SHALL take the region codes, MMIO offsets (0x08, 0x18, 0x20, 0x30) and size encodings from the shared package mmio_pkg; the read-side select uses the same package.
REQ-035 SHALL place both counters and the clear logic in the sub-module mmio_counters.

Verification
REQ-036 SHALL verify: sb with addr=0x1000_0003, wdata=0xAB → dmem_wea=1000, dmem_dina=0xABABABAB, imem_wea=0000.
REQ-037 SHALL verify: sw to 0x8000_0008, wdata=0x41, with trmt_ready=0 → trmt_valid=1, trmt_data=0x41; a second sw of 0x42 before ready → trmt_data stays 0x41 and tx_overrun=1.
REQ-038 SHALL verify: 10 cycles with inst_retire high on 4 of them → counter_cycle advances by 10 and counter_inst by 4; sw to 0x8000_0018 with inst_retire=1 → both counters read 0.
REQ-039 SHALL verify: counter_cycle forced to 0xFFFF_FFFF → next value 0.
REQ-040 SHALL verify: sh to 0x3000_0001 → all enables 0 and misalign pulsed for one cycle; sw to 0x8000_0030 with wdata=0x3F → leds=0x3F.
REQ-041 SHALL verify: rst_n low mid-transmit → trmt_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared MMIO store-path constants: region codes, MMIO offsets, size codes.
package mmio_pkg;

  // Region codes in addr[31:28]
  localparam logic [3:0] RGN_DMEM = 4'b0001;
  localparam logic [3:0] RGN_IMEM = 4'b0010;
  localparam logic [3:0] RGN_BOTH = 4'b0011;
  localparam logic [3:0] RGN_MMIO = 4'b1000;

  // MMIO register offsets (addr[27:0])
  localparam logic [27:0] OFF_TX   = 28'h000_0008;
  localparam logic [27:0] OFF_CCLR = 28'h000_0018;
  localparam logic [27:0] OFF_BTN  = 28'h000_0020;
  localparam logic [27:0] OFF_LED  = 28'h000_0030;

  // Store size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Decoded store target
  typedef struct packed {
    logic dmem;
    logic imem;
    logic mmio;
  } tgt_t;

  function automatic tgt_t decode_region(input logic [3:0] rgn);
    tgt_t t;
    t.dmem = (rgn == RGN_DMEM) || (rgn == RGN_BOTH);
    t.imem = (rgn == RGN_IMEM) || (rgn == RGN_BOTH);
    t.mmio = (rgn == RGN_MMIO);
    return t;
  endfunction

  // Reserved size counts as misaligned so it can never write anything.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      SZ_WORD: m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << a;
      SZ_HALF: m = 4'b0011 << a;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the right-aligned store data into every lane it could land in.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmio_counters.sv
// Free-running cycle counter and retired-instruction counter with MMIO clear.
module mmio_counters
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_retire,
  output logic [31:0] o_cycle,
  output logic [31:0] o_inst
);

  logic [31:0] r_cycle;
  logic [31:0] r_inst;

  // Count every cycle / every retire; a clear store overrides the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= '0;
      r_inst  <= '0;
    end else if (i_clr) begin
      r_cycle <= '0;
      r_inst  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (i_retire) r_inst <= r_inst + 32'd1;
    end
  end

  assign o_cycle = r_cycle;
  assign o_inst  = r_inst;

endmodule

// File: rtl/mmio_wsel.sv
// Store write-select: decodes a CPU store into dmem/imem byte-lane writes
// or MMIO side effects (UART TX, counter clear, button pop, LEDs).
module mmio_wsel
  import mmio_pkg::*;
#(
  parameter int LED_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [1:0]       size,
  input  logic             inst_retire,
  input  logic             trmt_ready,
  output logic [3:0]       dmem_wea,
  output logic [3:0]       imem_wea,
  output logic [31:0]      dmem_dina,
  output logic [31:0]      imem_dina,
  output logic [7:0]       trmt_data,
  output logic             trmt_valid,
  output logic [31:0]      counter_cycle,
  output logic [31:0]      counter_inst,
  output logic [LED_W-1:0] leds,
  output logic             buttons_rd_en,
  output logic             tx_overrun,
  output logic             misalign
);

  tgt_t        w_tgt;
  logic        w_mis;
  logic        w_ok;
  logic [3:0]  w_mask;
  logic [31:0] w_lanes;
  logic        w_mmio_wr;
  logic [27:0] w_off;
  logic        w_wr_tx;
  logic        w_wr_clr;
  logic        w_wr_btn;
  logic        w_wr_led;
  logic        w_hs;
  logic        w_tx_block;

  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_overrun;
  logic             r_btn;
  logic             r_mis;
  logic [LED_W-1:0] r_leds;

  // Decode: a store only acts if it is valid, aligned and hits a known region.
  assign w_tgt   = decode_region(addr[31:28]);
  assign w_mis   = is_misaligned(size, addr[1:0]);
  assign w_ok    = we && !w_mis;
  assign w_mask  = lane_mask(size, addr[1:0]);
  assign w_lanes = lane_data(size, wdata);
  assign w_off   = addr[27:0];

  // Memory write ports are purely combinational, same cycle as we.
  assign dmem_wea  = (w_ok && w_tgt.dmem) ? w_mask : 4'b0000;
  assign imem_wea  = (w_ok && w_tgt.imem) ? w_mask : 4'b0000;
  assign dmem_dina = w_lanes;
  assign imem_dina = w_lanes;

  assign w_mmio_wr = w_ok && w_tgt.mmio;
  assign w_wr_tx   = w_mmio_wr && (w_off == OFF_TX);
  assign w_wr_clr  = w_mmio_wr && (w_off == OFF_CCLR);
  assign w_wr_btn  = w_mmio_wr && (w_off == OFF_BTN);
  assign w_wr_led  = w_mmio_wr && (w_off == OFF_LED);

  // A TX store is only refused while a byte is held and not being taken now.
  assign w_hs       = r_tx_valid && trmt_ready;
  assign w_tx_block = r_tx_valid && !trmt_ready;

  // UART TX holding register; a store coinciding with a handshake reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_wr_tx && !w_tx_block) begin
      r_tx_data  <= wdata[7:0];
      r_tx_valid <= 1'b1;
    end else if (w_hs) begin
      r_tx_valid <= 1'b0;
    end
  end

  // Sticky overrun: a TX store was dropped because the holding reg was busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_overrun <= 1'b0;
    else if (w_wr_tx && w_tx_block)  r_overrun <= 1'b1;
  end

  // One-cycle pulses: button FIFO pop and misaligned-store flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn <= 1'b0;
      r_mis <= 1'b0;
    end else begin
      r_btn <= w_wr_btn;
      r_mis <= we && w_mis && (w_tgt.dmem || w_tgt.imem || w_tgt.mmio);
    end
  end

  // LED register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_leds <= '0;
    else if (w_wr_led) r_leds <= wdata[LED_W-1:0];
  end

  mmio_counters u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_wr_clr),
    .i_retire (inst_retire),
    .o_cycle  (counter_cycle),
    .o_inst   (counter_inst)
  );

  assign trmt_data     = r_tx_data;
  assign trmt_valid    = r_tx_valid;
  assign tx_overrun    = r_overrun;
  assign buttons_rd_en = r_btn;
  assign misalign      = r_mis;
  assign leds          = r_leds;

endmodule

// File: tb/tb_mmio_wsel.sv
// Directed bench for mmio_wsel with a scoreboard on the memory write ports.
module tb_mmio_wsel;

  localparam int LED_W = 6;

  logic             clk, rst_n, we, inst_retire, trmt_ready;
  logic [31:0]      addr, wdata;
  logic [1:0]       size;
  logic [3:0]       dmem_wea, imem_wea;
  logic [31:0]      dmem_dina, imem_dina;
  logic [7:0]       trmt_data;
  logic             trmt_valid, buttons_rd_en, tx_overrun, misalign;
  logic [31:0]      counter_cycle, counter_inst;
  logic [LED_W-1:0] leds;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  dwe;
    logic [3:0]  iwe;
    logic [31:0] dat;
    logic        chk_dat;
  } mem_exp_t;

  mem_exp_t mem_q[$];

  mmio_wsel #(.LED_W(LED_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .size(size),
    .inst_retire(inst_retire), .trmt_ready(trmt_ready),
    .dmem_wea(dmem_wea), .imem_wea(imem_wea), .dmem_dina(dmem_dina), .imem_dina(imem_dina),
    .trmt_data(trmt_data), .trmt_valid(trmt_valid),
    .counter_cycle(counter_cycle), .counter_inst(counter_inst), .leds(leds),
    .buttons_rd_en(buttons_rd_en), .tx_overrun(tx_overrun), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge then settle: registered results are stable and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    we = 1'b1; addr = a; wdata = d; size = sz;
  endtask

  task automatic idle();
    we = 1'b0; addr = '0; wdata = '0; size = 2'b00;
  endtask

  task automatic mem_push(input logic [3:0] dw, input logic [3:0] iw,
                          input logic [31:0] dat, input logic cd);
    mem_exp_t e;
    e.dwe = dw; e.iwe = iw; e.dat = dat; e.chk_dat = cd;
    mem_q.push_back(e);
  endtask

  task automatic mem_pop_chk(input string tag);
    mem_exp_t e;
    if (mem_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = mem_q.pop_front();
      chk({tag, ".dwea"}, {28'd0, dmem_wea}, {28'd0, e.dwe});
      chk({tag, ".iwea"}, {28'd0, imem_wea}, {28'd0, e.iwe});
      if (e.chk_dat) begin
        if (e.dwe != 4'b0000) chk({tag, ".ddin"}, dmem_dina, e.dat);
        if (e.iwe != 4'b0000) chk({tag, ".idin"}, imem_dina, e.dat);
      end
    end
  endtask

  // Drive one store, check the combinational memory ports, then take the edge.
  task automatic mem_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic [3:0] dw, input logic [3:0] iw,
                           input logic [31:0] dat, input logic cd);
    store(a, d, sz);
    mem_push(dw, iw, dat, cd);
    #1;
    mem_pop_chk(tag);
    tick();
    idle();
  endtask

  logic [31:0] c0, i0;
  logic [9:0]  pat;

  initial begin
    rst_n = 1'b0; inst_retire = 1'b0; trmt_ready = 1'b0;
    idle();
    #3;
    chk("rst.valid",   {31'd0, trmt_valid}, 32'd0);
    chk("rst.data",    {24'd0, trmt_data}, 32'd0);
    chk("rst.cycle",   counter_cycle, 32'd0);
    chk("rst.inst",    counter_inst, 32'd0);
    chk("rst.leds",    {26'd0, leds}, 32'd0);
    chk("rst.btn",     {31'd0, buttons_rd_en}, 32'd0);
    chk("rst.ovr",     {31'd0, tx_overrun}, 32'd0);
    chk("rst.mis",     {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("resume.cycle", counter_cycle, 32'd1);

    // Memory path
    mem_store("sb_d",   32'h1000_0003, 32'h0000_00AB, 2'b00, 4'b1000, 4'b0000, 32'hABAB_ABAB, 1'b1);
    mem_store("sh_i",   32'h2000_0002, 32'h0000_1234, 2'b01, 4'b0000, 4'b1100, 32'h1234_1234, 1'b1);
    mem_store("sw_b",   32'h3000_0000, 32'hDEAD_BEEF, 2'b10, 4'b1111, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    mem_store("sb_rgn", 32'h4000_0001, 32'h0000_0055, 2'b00, 4'b0000, 4'b0000, 32'h0, 1'b0);
    chk("rgn.mis", {31'd0, misalign}, 32'd0);
    mem_store("sz11",   32'h1000_0000, 32'h0000_0011, 2'b11, 4'b0000, 4'b0000, 32'h0, 1'b0);
    chk("sz11.mis", {31'd0, misalign}, 32'd1);
    tick();
    mem_store("sh_mis", 32'h3000_0001, 32'h0000_BEEF, 2'b01, 4'b0000, 4'b0000, 32'h0, 1'b0);
    chk("mis.pulse", {31'd0, misalign}, 32'd1);
    tick();
    chk("mis.clear", {31'd0, misalign}, 32'd0);

    // LEDs
    mem_store("sw_led", 32'h8000_0030, 32'h0000_003F, 2'b10, 4'b0000, 4'b0000, 32'h0, 1'b0);
    chk("leds", {26'd0, leds}, 32'h3F);
    store(32'h8000_0034, 32'h0000_0001, 2'b10);
    tick(); idle();
    chk("leds.other_off", {26'd0, leds}, 32'h3F);

    // UART TX
    trmt_ready = 1'b0;
    mem_store("sw_tx1", 32'h8000_0008, 32'h0000_0041, 2'b10, 4'b0000, 4'b0000, 32'h0, 1'b0);
    chk("tx1.valid", {31'd0, trmt_valid}, 32'd1);
    chk("tx1.data",  {24'd0, trmt_data}, 32'h41);
    chk("tx1.ovr",   {31'd0, tx_overrun}, 32'd0);
    store(32'h8000_0008, 32'h0000_0042, 2'b10);
    tick(); idle();
    chk("tx2.data",  {24'd0, trmt_data}, 32'h41);
    chk("tx2.ovr",   {31'd0, tx_overrun}, 32'd1);
    trmt_ready = 1'b1;
    store(32'h8000_0008, 32'h0000_0043, 2'b10);
    tick(); idle();
    chk("tx3.valid", {31'd0, trmt_valid}, 32'd1);
    chk("tx3.data",  {24'd0, trmt_data}, 32'h43);
    tick();
    chk("tx.hs",     {31'd0, trmt_valid}, 32'd0);
    trmt_ready = 1'b0;
    tick();
    chk("tx.ovr_sticky", {31'd0, tx_overrun}, 32'd1);

    // Button pop pulse
    store(32'h8000_0020, 32'h0, 2'b10);
    tick(); idle();
    chk("btn.pulse", {31'd0, buttons_rd_en}, 32'd1);
    tick();
    chk("btn.clear", {31'd0, buttons_rd_en}, 32'd0);

    // Counters: 10 cycles, retire on 4 of them
    c0 = counter_cycle; i0 = counter_inst;
    pat = 10'b0100011010;
    for (int k = 0; k < 10; k++) begin
      inst_retire = pat[k];
      tick();
    end
    inst_retire = 1'b0;
    chk("cnt.cycle_d10", counter_cycle, c0 + 32'd10);
    chk("cnt.inst_d4",   counter_inst,  i0 + 32'd4);
    store(32'h8000_0018, 32'h0, 2'b10);
    inst_retire = 1'b1;
    tick(); idle();
    inst_retire = 1'b0;
    chk("clr.cycle", counter_cycle, 32'd0);
    chk("clr.inst",  counter_inst,  32'd0);

    // Wrap
    force dut.u_cnt.r_cycle = 32'hFFFF_FFFF;
    #1;
    chk("wrap.pre", counter_cycle, 32'hFFFF_FFFF);
    release dut.u_cnt.r_cycle;
    tick();
    chk("wrap.post", counter_cycle, 32'd0);

    // Async reset with a byte pending
    trmt_ready = 1'b0;
    store(32'h8000_0008, 32'h0000_0055, 2'b10);
    tick(); idle();
    chk("rtx.valid", {31'd0, trmt_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, trmt_valid}, 32'd0);
    chk("arst.data",  {24'd0, trmt_data}, 32'd0);
    chk("arst.ovr",   {31'd0, tx_overrun}, 32'd0);
    chk("arst.leds",  {26'd0, leds}, 32'd0);
    chk("arst.cycle", counter_cycle, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst.resume", counter_cycle, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
